// File: rtl/bf_io_pkg.sv
// Shared definitions for the byte-stream I/O bridge: FSM encoding and default sizes.
package bf_io_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_IN_DEPTH  = 16;
   localparam int DEF_OUT_DEPTH = 16;
   localparam int DEF_CNT_W     = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_WAIT_IN = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } bf_state_e;

   // States in which the core is executing and the cycle counter advances.
   function automatic logic is_active(input bf_state_e s);
      return (s == ST_RUN) || (s == ST_WAIT_IN);
   endfunction

endpackage

// File: rtl/bf_io_fifo.sv
// Synchronous FIFO with registered pointers and an occupancy count.
// A push while full is accepted only when a pop frees the slot in the same cycle;
// a pop while empty is ignored, so a simultaneous push still lands.
module bf_io_fifo
   import bf_io_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_W,
   parameter int DEPTH = DEF_IN_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/bf_io_bridge.sv
// Bridges a host byte stream to a core that reads/writes one cell at a time,
// with run control, drain-on-halt and an optional cycle-count timeout.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IDLE     | after reset, waiting for the first cycle with en=1
//  RUN      | core executing; reads served from the input FIFO
//  WAIT_IN  | core read pending on an empty input FIFO, waiting for host data
//  DRAIN    | core halted; waiting for the host to empty the output FIFO
//  DONE     | finished (drained or timed out); terminal until reset
module bf_io_bridge
   import bf_io_pkg::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                IN_DEPTH  = DEF_IN_DEPTH,
   parameter int                OUT_DEPTH = DEF_OUT_DEPTH,
   parameter int                CNT_W     = DEF_CNT_W,
   parameter logic [DATA_W-1:0] EOF_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] host_in_data,
   input  logic              host_in_valid,
   output logic              host_in_ready,
   input  logic              host_in_eof,
   input  logic              core_rd_req,
   output logic [DATA_W-1:0] core_rd_data,
   output logic              core_rd_ack,
   input  logic              core_wr_valid,
   input  logic [DATA_W-1:0] core_wr_data,
   output logic              core_wr_ready,
   input  logic              core_halt,
   output logic [DATA_W-1:0] host_out_data,
   output logic              host_out_valid,
   input  logic              host_out_ready,
   input  logic [CNT_W-1:0]  timeout_limit,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              done,
   output logic              timed_out
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   bf_state_e state;
   bf_state_e state_nxt;

   logic                     in_push;
   logic                     in_pop;
   logic                     in_full;
   logic                     in_empty;
   logic [DATA_W-1:0]        in_head;
   logic [$clog2(IN_DEPTH):0]  unused_in_count;
   logic                     out_push;
   logic                     out_pop;
   logic                     out_full;
   logic                     out_empty;
   logic [$clog2(OUT_DEPTH):0] unused_out_count;
   logic                     wr_open;
   logic                     rd_serve;
   logic                     eof_ack;
   logic                     limit_hit;
   logic                     cnt_step;

   bf_io_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_push),
      .wr_data (host_in_data),
      .pop     (in_pop),
      .rd_data (in_head),
      .count   (unused_in_count),
      .full    (in_full),
      .empty   (in_empty)
   );

   bf_io_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (out_push),
      .wr_data (core_wr_data),
      .pop     (out_pop),
      .rd_data (host_out_data),
      .count   (unused_out_count),
      .full    (out_full),
      .empty   (out_empty)
   );

   // Host-side handshakes run in every state, independent of en.
   assign host_in_ready  = !in_full;
   assign in_push        = host_in_valid && host_in_ready;
   assign host_out_valid = !out_empty;
   assign out_pop        = host_out_valid && host_out_ready;

   // A full output FIFO still takes a write when the host drains its head that cycle.
   assign wr_open       = (state == ST_RUN) || (state == ST_WAIT_IN) || (state == ST_DRAIN);
   assign core_wr_ready = wr_open && (!out_full || out_pop);
   assign out_push      = core_wr_valid && core_wr_ready;

   assign done = (state == ST_DONE);

   // Next-state and read-service decisions; timeout beats halt, halt beats reads.
   always_comb begin
      state_nxt = state;
      rd_serve  = 1'b0;
      in_pop    = 1'b0;
      eof_ack   = 1'b0;
      limit_hit = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (en) state_nxt = ST_RUN;
         end
         ST_RUN, ST_WAIT_IN: begin
            if (en) begin
               if ((timeout_limit != '0) && (cycle_count == timeout_limit)) begin
                  limit_hit = 1'b1;
                  state_nxt = ST_DONE;
               end else if (core_halt) begin
                  state_nxt = ST_DRAIN;
               end else begin
                  // A request seen while its ack is on the bus is the same read, not a new one.
                  rd_serve = (state == ST_WAIT_IN) || (core_rd_req && !core_rd_ack);
                  if (rd_serve) begin
                     if (!in_empty) begin
                        in_pop    = 1'b1;
                        state_nxt = ST_RUN;
                     end else if (host_in_eof) begin
                        eof_ack   = 1'b1;
                        state_nxt = ST_RUN;
                     end else begin
                        state_nxt = ST_WAIT_IN;
                     end
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (en && out_empty) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_DONE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      cnt_step = en && is_active(state) && !limit_hit;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Registered read return: one-cycle ack, data held until the next served read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_rd_ack  <= 1'b0;
         core_rd_data <= '0;
      end else begin
         core_rd_ack <= in_pop || eof_ack;
         if (in_pop)       core_rd_data <= in_head;
         else if (eof_ack) core_rd_data <= EOF_VALUE;
      end
   end

   // Saturating run-cycle counter and sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_count <= '0;
         timed_out   <= 1'b0;
      end else begin
         if (cnt_step && !(&cycle_count)) cycle_count <= cycle_count + CNT_ONE;
         if (limit_hit) timed_out <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bf_io_bridge.sv
// Bench for bf_io_bridge: transaction-level model (queues + run flags) compared on
// every negedge, directed scenarios with literal expectations, then random traffic.
module tb_bf_io_bridge;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [DW-1:0] host_in_data = '0;
   logic          host_in_valid = 1'b0;
   logic          host_in_ready;
   logic          host_in_eof = 1'b0;
   logic          core_rd_req = 1'b0;
   logic [DW-1:0] core_rd_data;
   logic          core_rd_ack;
   logic          core_wr_valid = 1'b0;
   logic [DW-1:0] core_wr_data = '0;
   logic          core_wr_ready;
   logic          core_halt = 1'b0;
   logic [DW-1:0] host_out_data;
   logic          host_out_valid;
   logic          host_out_ready = 1'b0;
   logic [CW-1:0] timeout_limit = '0;
   logic [CW-1:0] cycle_count;
   logic          done;
   logic          timed_out;

   always #5 clk = ~clk;

   bf_io_bridge #(
      .DATA_W(DW), .IN_DEPTH(DEPTH), .OUT_DEPTH(DEPTH), .CNT_W(CW), .EOF_VALUE(8'h00)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .host_in_data(host_in_data), .host_in_valid(host_in_valid),
      .host_in_ready(host_in_ready), .host_in_eof(host_in_eof),
      .core_rd_req(core_rd_req), .core_rd_data(core_rd_data), .core_rd_ack(core_rd_ack),
      .core_wr_valid(core_wr_valid), .core_wr_data(core_wr_data),
      .core_wr_ready(core_wr_ready), .core_halt(core_halt),
      .host_out_data(host_out_data), .host_out_valid(host_out_valid),
      .host_out_ready(host_out_ready), .timeout_limit(timeout_limit),
      .cycle_count(cycle_count), .done(done), .timed_out(timed_out)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_in_q[$];
   logic [DW-1:0] m_out_q[$];
   bit            m_started, m_waiting, m_halted, m_finished, m_timed_out, m_ack;
   logic [DW-1:0] m_rdata;
   logic [CW-1:0] m_cnt;
   bit            f_hin, f_hout, f_wr, f_ack;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_in_q.delete(); m_out_q.delete();
         m_started = 0; m_waiting = 0; m_halted = 0; m_finished = 0;
         m_timed_out = 0; m_ack = 0; m_rdata = '0; m_cnt = '0;
      end else begin
         f_hin  = host_in_valid && (m_in_q.size() < DEPTH);
         f_hout = host_out_ready && (m_out_q.size() > 0);
         f_wr   = core_wr_valid && m_started && !m_finished &&
                  ((m_out_q.size() < DEPTH) || f_hout);
         f_ack  = 0;
         if (en && m_started && !m_halted && !m_finished) begin
            if (timeout_limit != 0 && m_cnt == timeout_limit) begin
               m_finished = 1; m_timed_out = 1; m_waiting = 0;
            end else begin
               if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
               if (core_halt) begin
                  m_halted = 1; m_waiting = 0;
               end else if (m_waiting || (core_rd_req && !m_ack)) begin
                  if (m_in_q.size() > 0) begin
                     m_rdata = m_in_q.pop_front(); f_ack = 1; m_waiting = 0;
                  end else if (host_in_eof) begin
                     m_rdata = 8'h00; f_ack = 1; m_waiting = 0;
                  end else begin
                     m_waiting = 1;
                  end
               end
            end
         end else if (en && m_halted && !m_finished) begin
            if (m_out_q.size() == 0) m_finished = 1;
         end else if (en && !m_started) begin
            m_started = 1;
         end
         m_ack = f_ack;
         if (f_hout) void'(m_out_q.pop_front());
         if (f_wr)   m_out_q.push_back(core_wr_data);
         if (f_hin)  m_in_q.push_back(host_in_data);
      end
   end

   // Compare every cycle, mid-period.
   always @(negedge clk) begin
      chk("host_in_ready", host_in_ready, m_in_q.size() < DEPTH);
      chk("host_out_valid", host_out_valid, m_out_q.size() != 0);
      if (m_out_q.size() != 0) chk("host_out_data", host_out_data, m_out_q[0]);
      chk("core_wr_ready", core_wr_ready, m_started && !m_finished &&
          ((m_out_q.size() < DEPTH) || (host_out_ready && m_out_q.size() != 0)));
      chk("core_rd_ack", core_rd_ack, m_ack);
      chk("core_rd_data", core_rd_data, m_rdata);
      chk("done", done, m_finished);
      chk("timed_out", timed_out, m_timed_out);
      chk("cycle_count", cycle_count, m_cnt);
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      host_in_valid = 0; host_in_eof = 0; core_rd_req = 0;
      core_wr_valid = 0; core_halt = 0; host_out_ready = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1; en = 0; timeout_limit = '0; idle_inputs();
      repeat (2) @(posedge clk);
      #3 rst = 0;
      cyc();
   endtask

   task automatic core_read(input logic [DW-1:0] exp, input string name);
      int n = 0;
      core_rd_req = 1;
      do begin cyc(); n++; end while (!core_rd_ack && n < 50);
      core_rd_req = 0;
      chk({name, "_ack"}, core_rd_ack, 1'b1);
      chk({name, "_data"}, core_rd_data, exp);
      chk({name, "_latency"}, n, 1);
   endtask

   task automatic host_push(input logic [DW-1:0] d);
      host_in_valid = 1; host_in_data = d; cyc(); host_in_valid = 0;
   endtask

   task automatic core_write(input logic [DW-1:0] d);
      core_wr_valid = 1; core_wr_data = d; cyc(); core_wr_valid = 0;
   endtask

   initial begin
      #1_000_000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      idle_inputs();
      do_reset();
      chk("reset_cycle_count", cycle_count, 0);
      chk("reset_done", done, 0);
      chk("reset_in_ready", host_in_ready, 1);
      chk("reset_out_valid", host_out_valid, 0);
      chk("reset_wr_ready", core_wr_ready, 0);

      // Two buffered bytes read back-to-back, each acked one cycle after request.
      en = 1;
      host_push(8'h48);
      host_push(8'h69);
      core_read(8'h48, "rd1");
      cyc();
      core_read(8'h69, "rd2");
      cyc();

      // Read on empty input waits, then completes once host data arrives.
      core_rd_req = 1;
      for (int i = 0; i < 5; i++) begin cyc(); chk("wait_no_ack", core_rd_ack, 0); end
      host_push(8'h2A);
      chk("wait_push_cycle_no_ack", core_rd_ack, 0);
      n = 0;
      do begin cyc(); n++; end while (!core_rd_ack && n < 20);
      core_rd_req = 0;
      chk("wait_ack_latency", n, 1);
      chk("wait_ack_data", core_rd_data, 8'h2A);
      cyc();
      host_in_eof = 1;
      core_read(8'h00, "eof_rd");
      host_in_eof = 0;
      cyc();

      // Fill the output FIFO, then write into a full FIFO while the host pops.
      host_out_ready = 0;
      for (int i = 0; i < DEPTH; i++) begin
         core_wr_valid = 1; core_wr_data = 8'(i); #1;
         chk("fill_wr_ready", core_wr_ready, 1);
         cyc();
      end
      core_wr_valid = 0; #1;
      chk("full_wr_ready", core_wr_ready, 0);
      host_out_ready = 1; core_wr_valid = 1; core_wr_data = 8'h10; #1;
      chk("full_head", host_out_data, 8'h00);
      chk("full_pop_wr_ready", core_wr_ready, 1);
      cyc();
      host_out_ready = 0; core_wr_valid = 0; #1;
      chk("still_full_wr_ready", core_wr_ready, 0);
      chk("still_full_head", host_out_data, 8'h01);
      host_out_ready = 1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_valid", host_out_valid, 1);
         chk("drain_data", host_out_data, 8'(i + 1));
         cyc();
      end
      host_out_ready = 0;
      chk("drain_empty", host_out_valid, 0);

      // Halt with queued output drains, then finishes without timeout.
      do_reset();
      en = 1; cyc();
      core_write(8'hA1); core_write(8'hA2); core_write(8'hA3);
      core_halt = 1; cyc(); core_halt = 0;
      repeat (3) cyc();
      chk("drain_not_done", done, 0);
      chk("drain_wr_ready", core_wr_ready, 1);
      host_out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         chk("halt_out_data", host_out_data, 8'hA1 + 8'(i));
         cyc();
      end
      n = 0;
      while (!done && n < 10) begin cyc(); n++; end
      host_out_ready = 0;
      chk("halt_done", done, 1);
      chk("halt_timed_out", timed_out, 0);
      chk("done_wr_ready", core_wr_ready, 0);
      chk("done_in_ready", host_in_ready, 1);

      // Timeout at a limit of 100 run cycles.
      do_reset();
      timeout_limit = 32'd100; en = 1;
      n = 0;
      while (!done && n < 400) begin cyc(); n++; end
      chk("to_done", done, 1);
      chk("to_timed_out", timed_out, 1);
      chk("to_cycle_count", cycle_count, 32'd100);
      repeat (3) cyc();
      chk("to_count_frozen", cycle_count, 32'd100);

      // Reset mid-WAIT_IN with bytes queued in the output FIFO.
      do_reset();
      en = 1; cyc();
      host_push(8'h5C);
      core_read(8'h5C, "pre_rst_rd");
      cyc();
      for (int i = 0; i < 4; i++) core_write(8'hC0 + 8'(i));
      core_rd_req = 1;
      repeat (3) cyc();
      chk("pre_rst_out_valid", host_out_valid, 1);
      rst = 1; en = 0; core_rd_req = 0; #1;
      chk("rst_out_valid", host_out_valid, 0);
      chk("rst_rd_ack", core_rd_ack, 0);
      chk("rst_rd_data", core_rd_data, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", host_in_ready, 1);
      chk("rst_wr_ready", core_wr_ready, 0);
      repeat (2) @(posedge clk);
      #3 rst = 0;
      repeat (2) cyc();
      chk("post_rst_idle", core_wr_ready, 0);

      // Randomized traffic against the model.
      for (int run = 0; run < 6; run++) begin
         int ready_pct;
         do_reset();
         timeout_limit = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(150, 900)) : '0;
         ready_pct = $urandom_range(20, 90);
         for (int c = 0; c < 1500; c++) begin
            en             = ($urandom_range(0, 9) != 0);
            host_in_valid  = ($urandom_range(0, 1) == 1);
            host_in_data   = 8'($urandom);
            host_in_eof    = (c > 900) && ($urandom_range(0, 3) == 0);
            core_wr_valid  = ($urandom_range(0, 2) == 0);
            core_wr_data   = 8'($urandom);
            host_out_ready = ($urandom_range(1, 100) <= ready_pct);
            core_halt      = (c > 1100) && ($urandom_range(0, 59) == 0);
            if (core_rd_ack)       core_rd_req = 0;
            else if (!core_rd_req) core_rd_req = ($urandom_range(0, 3) == 0);
            cyc();
         end
         idle_inputs();
      end

      cyc();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
